// File: rtl/mux8_arb_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter:
// requester count, select/hold-counter widths, FSM state encoding and
// a one-hot decode helper.
package mux8_arb_pkg;

  localparam int N      = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Binary index to one-hot requester vector.
  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker. Searches the unmasked requests starting
// one past ptr and wrapping modulo 8; reports the first hit. With ptr=7 the
// search order is 0..7, with ptr=i it is i+1..7 then 0..i.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N-1:0] cand;

  assign cand = req & ~mask;

  // Rotating priority search: first candidate after ptr wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      // Offset wraps naturally in SEL_W bits; k = N lands back on ptr.
      if (!found && cand[ptr + SEL_W'(k)]) begin
        found = 1'b1;
        idx   = ptr + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 bit mux.
// One requester at a time is granted (registered one-hot gnt and binary sel);
// the owner's data bit is forwarded on y. A releasing owner hands over to the
// next rotation winner without an idle bubble.
// Optional feature macro HOLD_LIMIT_EN: caps consecutive ownership at
// MAX_HOLD cycles while others are waiting, pulsing revoked on a forced
// hand-over. Without it revoked is constant 0 and owners hold indefinitely.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     x,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             y,
  output logic             revoked
);

  // Reject hold limits the 8-bit counter cannot represent.
  if (MAX_HOLD < 1 || MAX_HOLD > (1 << HOLD_W) - 1) begin : g_bad_max_hold
    $error("mux8_rr_arbiter: MAX_HOLD out of range 1..255");
  end

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_d;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             new_grant;

  logic [N-1:0]     pick_mask;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

`ifdef HOLD_LIMIT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q;
  logic              revoke_d;
`endif

  // While owning, the current owner is excluded so a hand-over always
  // targets someone else; when idle every request is eligible.
  assign pick_mask = (state_q == OWN) ? onehot(sel) : '0;

  rr_pick8 u_pick (
    .req   (req),
    .mask  (pick_mask),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and next-grant decision.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt;
    sel_d     = sel;
    ptr_d     = ptr_q;
    new_grant = 1'b0;
`ifdef HOLD_LIMIT_EN
    revoke_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) new_grant = 1'b1;
      end
      OWN: begin
        if (!req[sel]) begin
          if (pick_found) begin
            new_grant = 1'b1;
          end else begin
            // Nobody else waiting: go idle, sel keeps the last owner.
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
`ifdef HOLD_LIMIT_EN
        else if (hold_q == HOLD_LAST && pick_found) begin
          new_grant = 1'b1;
          revoke_d  = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    if (new_grant) begin
      state_d = OWN;
      gnt_d   = onehot(pick_idx);
      sel_d   = pick_idx;
      ptr_d   = pick_idx;
    end
  end

  // Arbitration state register; ptr=7 gives requester 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      ptr_q   <= SEL_W'(N - 1);
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef HOLD_LIMIT_EN
  // Hold counter: clears on each new grant, counts owned cycles, saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      revoked <= 1'b0;
    end else begin
      revoked <= revoke_d;
      if (new_grant) begin
        hold_q <= '0;
      end else if (state_q == OWN && hold_q != HOLD_LAST) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end
`else
  assign revoked = 1'b0;
`endif

  assign busy = |gnt;
  assign y    = busy & x[sel];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter. A behavioural model (integer
// owner/pointer bookkeeping) predicts every output each cycle; directed
// tests add hand-computed literal expectations. Build with or without
// HOLD_LIMIT_EN; with it the DUT runs at MAX_HOLD=4.
module tb_mux8_rr_arbiter;

`ifdef HOLD_LIMIT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] x   = '0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy, y, revoked;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  mux8_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .x       (x),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .y       (y),
    .revoked (revoked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner;  // -1 when idle
  int m_sel;
  int m_ptr;
  int m_hold;
  bit m_rev;

  function automatic int rr_next(input logic [7:0] r, input int p, input int excl);
    for (int k = 1; k <= 8; k++) begin
      int j;
      j = (p + k) % 8;
      if (j != excl && r[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_ptr = 7; m_hold = 0; m_rev = 0;
    end else begin
      m_rev = 0;
      w = -1;
      if (m_owner < 0) begin
        w = rr_next(req, m_ptr, -1);
      end else if (!req[m_owner]) begin
        w = rr_next(req, m_ptr, m_owner);
        if (w < 0) m_owner = -1;
      end
`ifdef HOLD_LIMIT_EN
      else if (m_hold >= MH - 1) begin
        w = rr_next(req, m_ptr, m_owner);
        if (w >= 0) m_rev = 1;
      end else begin
        m_hold++;
      end
`endif
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_ptr = w; m_hold = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    logic [31:0] e_gnt;
    #1;
    if (chk_en) begin
      e_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      check("gnt", 32'(gnt), e_gnt);
      check("sel", 32'(sel), 32'(m_sel));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("y", 32'(y), (m_owner >= 0) ? 32'(x[m_sel]) : 32'd0);
      check("revoked", 32'(revoked), 32'(m_rev));
    end
  end

  // ---------------- directed tests ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; x = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic at_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;

    // T1: reset mid-grant clears outputs at once, restart from ptr=7.
    @(negedge clk); req = 8'h04; x = 8'hFF;
    at_sample();
    check("t1_pre_gnt", 32'(gnt), 32'h04);
    #2; rst = 1'b1; #1;
    check("t1_rst_gnt", 32'(gnt), 32'h00);
    check("t1_rst_sel", 32'(sel), 32'd0);
    check("t1_rst_busy", 32'(busy), 32'd0);
    check("t1_rst_y", 32'(y), 32'd0);
    @(negedge clk); rst = 1'b0; req = 8'h01;
    at_sample();
    check("t1_restart_gnt", 32'(gnt), 32'h01);

    // T2: all requesting, each owner drops for one cycle after two.
    do_reset();
    @(negedge clk); req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      at_sample();
      check("t2_gnt_first", 32'(gnt), 32'd1 << (k % 8));
      check("t2_busy", 32'(busy), 32'd1);
      @(negedge clk); req = 8'hFF;
      at_sample();
      check("t2_gnt_second", 32'(gnt), 32'd1 << (k % 8));
      @(negedge clk); req = 8'hFF & ~(8'd1 << (k % 8));
    end
    @(negedge clk); req = '0;

    // T3: pointer wrap from 6.
    do_reset();
    @(negedge clk); req = 8'h40;
    at_sample();
    check("t3_gnt6", 32'(gnt), 32'h40);
    @(negedge clk); req = 8'h00;
    at_sample();
    check("t3_idle_gnt", 32'(gnt), 32'h00);
    check("t3_idle_sel", 32'(sel), 32'd6);
    @(negedge clk); req = 8'h41;
    at_sample();
    check("t3_wrap_gnt", 32'(gnt), 32'h01);
    @(negedge clk); req = 8'h40;
    at_sample();
    check("t3_handover_gnt", 32'(gnt), 32'h40);
    check("t3_handover_busy", 32'(busy), 32'd1);

    // T4: data path through owner 5.
    do_reset();
    @(negedge clk); req = 8'h20; x = 8'b0010_0000;
    at_sample();
    check("t4_sel5", 32'(sel), 32'd5);
    check("t4_y_one", 32'(y), 32'd1);
    @(negedge clk); x = 8'hDF; #1;
    check("t4_y_zero", 32'(y), 32'd0);
    req = 8'h00;
    at_sample();
    @(negedge clk); x = 8'hFF; #1;
    check("t4_idle_y", 32'(y), 32'd0);

    // T5: two requesters that never release.
    do_reset();
    @(negedge clk); req = 8'h03;
`ifdef HOLD_LIMIT_EN
    for (int c = 0; c < 9; c++) begin
      at_sample();
      check("t5_gnt", 32'(gnt), (c >= 4 && c < 8) ? 32'h02 : 32'h01);
      check("t5_revoked", 32'(revoked), 32'(c == 4 || c == 8));
    end
`else
    for (int c = 0; c < 100; c++) begin
      at_sample();
      check("t5_gnt", 32'(gnt), 32'h01);
      check("t5_revoked", 32'(revoked), 32'd0);
    end
`endif
    @(negedge clk); req = '0;

    // T6: lone owner releases.
    do_reset();
    @(negedge clk); req = 8'h08;
    at_sample();
    check("t6_gnt3", 32'(gnt), 32'h08);
    @(negedge clk); req = 8'h00;
    at_sample();
    check("t6_gnt", 32'(gnt), 32'h00);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_sel", 32'(sel), 32'd3);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
